bcd_sweep_ctrl: RTL and testbench

BCD_SWEEP_CTRL -- requirements
Module: bcd_sweep_ctrl

---
 rtl/bcd_sweep_pkg.sv | 18 +
 rtl/bcd_digit.sv | 33 +++
 rtl/bcd_sweep_ctrl.sv | 172 +++++++++++++++++
 tb/tb_bcd_sweep_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/bcd_sweep_pkg.sv
// Shared types and constants for the BCD sweep controller.
package bcd_sweep_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] MODE_UP_ONCE   = 2'b00;
  localparam logic [1:0] MODE_DOWN_ONCE = 2'b01;
  localparam logic [1:0] MODE_BOUNCE    = 2'b10;
  localparam logic [1:0] MODE_WRAP_UP   = 2'b11;

  localparam logic [3:0] NIB_MAX = 4'd9;

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the chained counter: +/-1 when carry_i is set, ripple out on 9->0 / 0->9.
module bcd_digit
  import bcd_sweep_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       carry_i,
  output logic [3:0] next_o,
  output logic       carry_o
);

  always_comb begin
    next_o  = value_i;
    carry_o = 1'b0;
    if (carry_i && inc_i) begin
      if (value_i >= NIB_MAX) begin
        next_o  = 4'd0;
        carry_o = 1'b1;
      end else begin
        next_o  = value_i + 4'd1;
      end
    end else if (carry_i && dec_i) begin
      if (value_i == 4'd0) begin
        next_o  = NIB_MAX;
        carry_o = 1'b1;
      end else begin
        next_o  = value_i - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_sweep_ctrl.sv
// Command-driven packed-BCD sweep counter: one-shot up/down, bounce and wrap modes.
module bcd_sweep_ctrl
  import bcd_sweep_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [1:0]            cmd_op_i,
  input  logic [1:0]            cmd_mode_i,
  input  logic [4*DIGITS-1:0]   cmd_lo_i,
  input  logic [4*DIGITS-1:0]   cmd_hi_i,
  input  logic                  step_i,
  output logic [4*DIGITS-1:0]   count_o,
  output logic                  dir_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int W = 4*DIGITS;

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d, lo_q, lo_d, hi_q, hi_d, stepped;
  logic [1:0]     mode_q, mode_d;
  logic           dir_q, dir_d, err_q, err_d;
  logic           step_inc, step_dec, lo_ok, hi_ok, at_lo, at_hi, stop_req, adv;
  logic [DIGITS:0] carry;

  always_comb begin
    lo_ok = 1'b1;
    hi_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cmd_lo_i[4*i +: 4] > NIB_MAX) lo_ok = 1'b0;
      if (cmd_hi_i[4*i +: 4] > NIB_MAX) hi_ok = 1'b0;
    end
  end

  assign at_lo    = (count_q == lo_q);
  assign at_hi    = (count_q == hi_q);
  assign stop_req = cmd_valid_i && (cmd_op_i == OP_STOP);
  assign adv      = (state_q == ST_RUN) && step_i && !stop_req;

  // Direction of the digit chain this cycle; bound hits are handled in the main block.
  always_comb begin
    step_inc = 1'b0;
    step_dec = 1'b0;
    case (mode_q)
      MODE_UP_ONCE:   step_inc = adv && !at_hi;
      MODE_DOWN_ONCE: step_dec = adv && !at_lo;
      MODE_BOUNCE: begin
        if (adv && !(at_lo && at_hi)) begin
          if (!dir_q) begin
            step_inc = !at_hi;
            step_dec = at_hi;
          end else begin
            step_dec = !at_lo;
            step_inc = at_lo;
          end
        end
      end
      MODE_WRAP_UP:   step_inc = adv && !at_hi;
      default: ;
    endcase
  end

  assign carry[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .value_i (count_q[4*g +: 4]),
      .inc_i   (step_inc),
      .dec_i   (step_dec),
      .carry_i (carry[g]),
      .next_o  (stepped[4*g +: 4]),
      .carry_o (carry[g+1])
    );
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dir_d   = dir_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          case (cmd_op_i)
            OP_START: begin
              if (lo_ok && hi_ok && (cmd_lo_i <= cmd_hi_i)) begin
                lo_d    = cmd_lo_i;
                hi_d    = cmd_hi_i;
                mode_d  = cmd_mode_i;
                state_d = ST_RUN;
                dir_d   = (cmd_mode_i == MODE_DOWN_ONCE);
                count_d = (cmd_mode_i == MODE_DOWN_ONCE) ? cmd_hi_i : cmd_lo_i;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_LOAD: begin
              if (lo_ok) count_d = cmd_lo_i;
              else       err_d   = 1'b1;
            end
            OP_CLEAR: begin
              count_d = '0;
              dir_d   = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        err_d = cmd_valid_i && (cmd_op_i != OP_STOP);
        if (stop_req) begin
          state_d = ST_IDLE;
        end else if (step_i) begin
          // A full-width carry would mean the count escaped its bounds; never commit it.
          if ((step_inc || step_dec) && !carry[DIGITS]) count_d = stepped;
          case (mode_q)
            MODE_UP_ONCE:   if (at_hi) state_d = ST_DONE;
            MODE_DOWN_ONCE: if (at_lo) state_d = ST_DONE;
            MODE_BOUNCE: begin
              if (at_lo && at_hi)        dir_d = !dir_q;
              else if (!dir_q && at_hi)  dir_d = 1'b1;
              else if (dir_q && at_lo)   dir_d = 1'b0;
            end
            MODE_WRAP_UP:   if (at_hi) count_d = lo_q;
            default: ;
          endcase
        end
        // Completion owns the next cycle's status; a rejected command on that edge is dropped.
        if (state_d == ST_DONE) err_d = 1'b0;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      dir_q   <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      mode_q  <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready_o = (state_q != ST_DONE);
  assign count_o     = count_q;
  assign dir_o       = dir_q;
  assign busy_o      = (state_q == ST_RUN);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_bcd_sweep_ctrl.sv
// Directed table-driven bench for bcd_sweep_ctrl (DIGITS=2) plus a few hand-written sequences.
module tb_bcd_sweep_ctrl;

  localparam logic [1:0] START = 2'b00, STOP = 2'b01, LOAD = 2'b10, CLEAR = 2'b11;
  localparam logic [1:0] UP = 2'b00, DOWN = 2'b01, BOUNCE = 2'b10, WRAP = 2'b11;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'b00, cmd_mode = 2'b00;
  logic [7:0] cmd_lo = 8'h00, cmd_hi = 8'h00;
  logic       step = 1'b0;
  logic [7:0] count;
  logic       dir, busy, done, err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_sweep_ctrl #(.DIGITS(2)) dut (
    .clk_i(clk), .reset_i(reset), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_mode_i(cmd_mode), .cmd_lo_i(cmd_lo), .cmd_hi_i(cmd_hi),
    .step_i(step), .count_o(count), .dir_o(dir), .busy_o(busy), .done_o(done), .err_o(err)
  );

  typedef struct {
    logic       rst, v;
    logic [1:0] op, mode;
    logic [7:0] lo, hi;
    logic       stp;
    logic [7:0] cnt;
    logic       dir, busy, done, err, rdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic v, logic [1:0] op, logic [1:0] mode,
                              logic [7:0] lo, logic [7:0] hi, logic stp, logic [7:0] cnt,
                              logic d, logic b, logic dn, logic e, logic r);
    vec_t t;
    t.rst = rst; t.v = v; t.op = op; t.mode = mode; t.lo = lo; t.hi = hi; t.stp = stp;
    t.cnt = cnt; t.dir = d; t.busy = b; t.done = dn; t.err = e; t.rdy = r;
    return t;
  endfunction

  // step while running, no command
  function automatic vec_t rs(logic [7:0] cnt, logic d);
    return mk(0, 0, START, UP, 8'h00, 8'h00, 1, cnt, d, 1, 0, 0, 1);
  endfunction

  // idle cycle with step high (must not move the count)
  function automatic vec_t id(logic [7:0] cnt, logic d, logic e);
    return mk(0, 0, START, UP, 8'h00, 8'h00, 1, cnt, d, 0, 0, e, 1);
  endfunction

  task automatic drive(input vec_t t);
    reset = t.rst; cmd_valid = t.v; cmd_op = t.op; cmd_mode = t.mode;
    cmd_lo = t.lo; cmd_hi = t.hi; step = t.stp;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [12:0] exp);
    logic [12:0] act;
    act = {count, dir, busy, done, err, cmd_ready};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got cnt=%h dir=%b busy=%b done=%b err=%b rdy=%b, want cnt=%h dir=%b busy=%b done=%b err=%b rdy=%b",
               name, act[12:5], act[4], act[3], act[2], act[1], act[0],
               exp[12:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    int cyc;
    logic [7:0] c;

    // reset, idle-step hold, UP_ONCE 08..12
    tbl.push_back(mk(1, 1, START, UP, 8'h08, 8'h12, 1, 8'h00, 0, 0, 0, 0, 1));
    tbl.push_back(id(8'h00, 0, 0));
    tbl.push_back(mk(0, 1, START, UP, 8'h08, 8'h12, 0, 8'h08, 0, 1, 0, 0, 1));
    tbl.push_back(rs(8'h09, 0));
    tbl.push_back(rs(8'h10, 0));
    tbl.push_back(rs(8'h11, 0));
    tbl.push_back(rs(8'h12, 0));
    tbl.push_back(mk(0, 0, START, UP, 8'h00, 8'h00, 1, 8'h12, 0, 0, 1, 0, 0));
    tbl.push_back(id(8'h12, 0, 0));
    // BOUNCE 03..05, STOP together with step
    tbl.push_back(mk(0, 1, START, BOUNCE, 8'h03, 8'h05, 0, 8'h03, 0, 1, 0, 0, 1));
    tbl.push_back(rs(8'h04, 0));
    tbl.push_back(rs(8'h05, 0));
    tbl.push_back(rs(8'h04, 1));
    tbl.push_back(rs(8'h03, 1));
    tbl.push_back(rs(8'h04, 0));
    tbl.push_back(mk(0, 1, STOP, UP, 8'h00, 8'h00, 1, 8'h04, 0, 0, 0, 0, 1));
    tbl.push_back(id(8'h04, 0, 0));
    // WRAP_UP 97..99, bad LOAD, inverted START, LOAD, CLEAR
    tbl.push_back(mk(0, 1, START, WRAP, 8'h97, 8'h99, 0, 8'h97, 0, 1, 0, 0, 1));
    tbl.push_back(rs(8'h98, 0));
    tbl.push_back(rs(8'h99, 0));
    tbl.push_back(rs(8'h97, 0));
    tbl.push_back(mk(0, 0, START, UP, 8'h00, 8'h00, 0, 8'h97, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, STOP, UP, 8'h00, 8'h00, 0, 8'h97, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, LOAD, UP, 8'h0A, 8'h00, 0, 8'h97, 0, 0, 0, 1, 1));
    tbl.push_back(id(8'h97, 0, 0));
    tbl.push_back(mk(0, 1, START, UP, 8'h20, 8'h10, 0, 8'h97, 0, 0, 0, 1, 1));
    tbl.push_back(id(8'h97, 0, 0));
    tbl.push_back(mk(0, 1, LOAD, UP, 8'h33, 8'h00, 0, 8'h33, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, CLEAR, UP, 8'h55, 8'h66, 0, 8'h00, 0, 0, 0, 0, 1));
    // DOWN_ONCE 10..00 with borrow, command ignored during DONE, LOAD keeps dir
    tbl.push_back(mk(0, 1, START, DOWN, 8'h00, 8'h10, 0, 8'h10, 1, 1, 0, 0, 1));
    tbl.push_back(rs(8'h09, 1));
    for (int k = 8; k >= 0; k--) begin
      c = 8'(k);
      tbl.push_back(rs(c, 1));
    end
    tbl.push_back(mk(0, 0, START, UP, 8'h00, 8'h00, 1, 8'h00, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, CLEAR, UP, 8'h00, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, LOAD, UP, 8'h25, 8'h00, 0, 8'h25, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, START, DOWN, 8'h00, 8'h03, 0, 8'h03, 1, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, STOP, UP, 8'h00, 8'h00, 1, 8'h03, 1, 0, 0, 0, 1));
    // reset mid-RUN, LOAD rejected in RUN while counting, err masked at completion
    tbl.push_back(mk(0, 1, START, UP, 8'h44, 8'h50, 0, 8'h44, 0, 1, 0, 0, 1));
    tbl.push_back(rs(8'h45, 0));
    tbl.push_back(mk(1, 1, LOAD, UP, 8'h11, 8'h00, 1, 8'h00, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, START, UP, 8'h40, 8'h42, 0, 8'h40, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, LOAD, UP, 8'h11, 8'h00, 1, 8'h41, 0, 1, 0, 1, 1));
    tbl.push_back(rs(8'h42, 0));
    tbl.push_back(mk(0, 1, START, UP, 8'h00, 8'h01, 1, 8'h42, 0, 0, 1, 0, 0));
    tbl.push_back(id(8'h42, 0, 0));
    // BOUNCE with lo==hi toggles dir only
    tbl.push_back(mk(0, 1, START, BOUNCE, 8'h07, 8'h07, 0, 8'h07, 0, 1, 0, 0, 1));
    tbl.push_back(rs(8'h07, 1));
    tbl.push_back(rs(8'h07, 0));
    tbl.push_back(mk(0, 0, START, UP, 8'h00, 8'h00, 0, 8'h07, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 1, STOP, UP, 8'h00, 8'h00, 0, 8'h07, 0, 0, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      check($sformatf("row%0d", i),
            {tbl[i].cnt, tbl[i].dir, tbl[i].busy, tbl[i].done, tbl[i].err, tbl[i].rdy});
    end

    // UP_ONCE with lo==hi finishes on the first step
    drive(mk(0, 1, START, UP, 8'h55, 8'h55, 0, 8'h00, 0, 0, 0, 0, 0));
    check("eq_start", {8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    drive(rs(8'h00, 0));
    check("eq_done", {8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    drive(id(8'h00, 0, 0));
    check("eq_idle", {8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});

    // 00..15 with step held: done after 16 step edges, bounded wait
    drive(mk(0, 1, START, UP, 8'h00, 8'h15, 0, 8'h00, 0, 0, 0, 0, 0));
    check("sweep_start", {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    cmd_valid = 1'b0;
    step = 1'b1;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (!done || cyc != 16) begin
      failures++;
      $display("FAIL sweep_len: got done=%b after %0d edges, want done=1 after 16", done, cyc);
    end
    check("sweep_end", {8'h15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
